// File: rtl/display_source_arbiter.sv
// display_source_arbiter: captures N_CH producer values and selects which one feeds the BCD converter.
//   clk        system clock
//   rst        asynchronous active-high reset
//   ch_valid   per-channel one-cycle capture strobe
//   ch_data    channel i value at [i*DATA_W +: DATA_W]
//   clr        synchronous clear of captured values, held flags and selection
//   scroll_en  1 = timed auto-scroll over held channels, 0 = last-event priority
//   sel_o      index of the displayed channel
//   data_o     displayed value (cap[sel_o], 0 for an unreachable index)
//   held_o     channels captured since reset/clr
//   upd_o      one-cycle pulse when a new sel_o/data_o first becomes visible
module display_source_arbiter #(
    parameter int N_CH = 3,
    parameter int DATA_W = 16,
    parameter int DWELL_CYC = 50_000_000,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic                   clr,
    input  logic                   scroll_en,
    output logic [SEL_W-1:0]       sel_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [N_CH-1:0]        held_o,
    output logic                   upd_o
);
    localparam int CNT_W = $clog2(DWELL_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYC - 1);

    typedef enum logic [1:0] {S_MANUAL, S_DWELL, S_ADVANCE} state_t;

    state_t            st;
    logic [DATA_W-1:0] cap [N_CH];
    logic [CNT_W-1:0]  cnt;
    logic              any_v;
    logic              has_above;
    logic [SEL_W-1:0]  hi, above, wrap, nxt, sel_n;
    logic [DATA_W-1:0] data_n;

    assign any_v = |ch_valid;

    // sel_n/data_n are the selection and displayed value after this edge, so upd_o
    // can be registered in the same cycle the change lands.
    always_comb begin
        hi = '0;
        above = '0;
        wrap = '0;
        has_above = 1'b0;
        data_o = '0;
        data_n = '0;
        for (int i = 0; i < N_CH; i++)
            if (ch_valid[i]) hi = SEL_W'(i);
        // descending scan leaves the lowest held index above sel_o, and the lowest held overall
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (held_o[i] && SEL_W'(i) > sel_o) begin
                above = SEL_W'(i);
                has_above = 1'b1;
            end
            if (held_o[i]) wrap = SEL_W'(i);
        end
        nxt = has_above ? above : wrap;
        sel_n = clr ? '0 : any_v ? hi : (st == S_ADVANCE && scroll_en) ? nxt : sel_o;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_o == SEL_W'(i)) data_o = cap[i];
            if (sel_n == SEL_W'(i)) data_n = clr ? '0 : ch_valid[i] ? ch_data[i*DATA_W +: DATA_W] : cap[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_MANUAL;
            cnt <= '0;
            sel_o <= '0;
            held_o <= '0;
            upd_o <= 1'b0;
            for (int i = 0; i < N_CH; i++) cap[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (clr) cap[i] <= '0;
                else if (ch_valid[i]) cap[i] <= ch_data[i*DATA_W +: DATA_W];
            held_o <= clr ? '0 : held_o | ch_valid;
            sel_o <= sel_n;
            upd_o <= (sel_n != sel_o) || (data_n != data_o);
            // the dwell timer restarts on any event and parks at CNT_MAX until the advance
            cnt <= (st == S_DWELL && scroll_en && !clr && !any_v && cnt != CNT_MAX) ? cnt + 1'b1 : '0;
            st <= !scroll_en ? S_MANUAL :
                  (st == S_DWELL && !clr && !any_v && cnt == CNT_MAX) ? S_ADVANCE : S_DWELL;
        end
    end
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb_display_source_arbiter: scoreboard bench for display_source_arbiter with a behavioural model.
module tb_display_source_arbiter;
    localparam int N = 3;
    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] ch_valid = '0;
    logic [N*W-1:0] ch_data = '0;
    logic         clr = 1'b0;
    logic         scroll_en = 1'b0;
    logic [1:0]   sel_o;
    logic [W-1:0] data_o;
    logic [N-1:0] held_o;
    logic         upd_o;

    display_source_arbiter #(.N_CH(N), .DATA_W(W), .DWELL_CYC(D)) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .clr(clr),
        .scroll_en(scroll_en), .sel_o(sel_o), .data_o(data_o), .held_o(held_o), .upd_o(upd_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         upd;
        logic [1:0]   sel;
        logic [W-1:0] data;
        logic [N-1:0] held;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   armed = 0;

    logic [W-1:0] m_cap [N];
    logic [N-1:0] m_held;
    int           m_sel;
    int           m_t;
    bit           m_mode;

    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic           rc;
    logic           rs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_cap[i] = '0;
        m_held = '0;
        m_sel = 0;
        m_t = 0;
        m_mode = 0;
    endtask

    // Model: m_t counts edges since the last scroll restart; the display moves on the
    // edge after D full dwell edges, to the next held channel in circular order.
    task automatic model(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic c, input logic s);
        int old_sel;
        logic [W-1:0] old_data;
        int n;
        bit found;
        exp_t e;
        old_sel = m_sel;
        old_data = m_cap[m_sel];
        if (c) begin
            for (int i = 0; i < N; i++) m_cap[i] = '0;
            m_held = '0;
            m_sel = 0;
            m_t = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (v[i]) begin
                    m_cap[i] = d[i*W +: W];
                    m_held[i] = 1'b1;
                    m_sel = i;
                end
            if (v != 0 || !m_mode || !s) m_t = 0;
            else if (m_t == D) begin
                n = 0;
                found = 0;
                for (int k = 1; k <= N; k++)
                    if (!found && m_held[(m_sel + k) % N]) begin
                        n = (m_sel + k) % N;
                        found = 1;
                    end
                m_sel = n;
                m_t = 0;
            end else m_t++;
        end
        m_mode = s;
        e.upd = (m_sel != old_sel) || (m_cap[m_sel] != old_data);
        e.sel = 2'(m_sel);
        e.data = m_cap[m_sel];
        e.held = m_held;
        sb.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic c, input logic s);
        @(negedge clk);
        ch_valid = v;
        ch_data = d;
        clr = c;
        scroll_en = s;
        model(v, d, c, s);
        armed = 1;
    endtask

    task automatic idle(input int n, input logic s);
        repeat (n) step('0, '0, 1'b0, s);
    endtask

    task automatic look(input string name, input logic [1:0] s, input logic [W-1:0] d, input logic [N-1:0] h);
        @(posedge clk);
        #2;
        chk({name, "_sel"}, 32'(sel_o), 32'(s));
        chk({name, "_data"}, 32'(data_o), 32'(d));
        chk({name, "_held"}, 32'(held_o), 32'(h));
    endtask

    // one expected entry is queued per stimulus cycle; the monitor retires it after the edge
    always @(posedge clk) begin
        #1;
        if (armed) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: no expected entry, got sel=%0d data=%0h", sel_o, data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("upd", 32'(upd_o), 32'(mon_e.upd));
                chk("sel", 32'(sel_o), 32'(mon_e.sel));
                chk("data", 32'(data_o), 32'(mon_e.data));
                chk("held", 32'(held_o), 32'(mon_e.held));
            end
        end
    end

    initial begin
        m_reset();
        @(negedge clk);
        chk("rst_sel", 32'(sel_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_held", 32'(held_o), 0);
        chk("rst_upd", 32'(upd_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20, 1'b0);
        look("idle", 2'd0, 16'h0, 3'b000);
        step(3'b001, {16'h0, 16'h0, 16'h0012}, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(3'b010, {16'h0, 16'h0034, 16'h0}, 1'b0, 1'b0);
        look("manual", 2'd1, 16'h0034, 3'b011);
        step(3'b111, {16'h00C8, 16'h0002, 16'h0001}, 1'b0, 1'b0);
        look("simul", 2'd2, 16'h00C8, 3'b111);
        step(3'b001, {16'h0, 16'h0, 16'h0005}, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(3'b001, {16'h0, 16'h0, 16'h0005}, 1'b0, 1'b0);
        idle(2, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        step(3'b100, {16'h00AA, 16'h0, 16'h0}, 1'b0, 1'b0);
        step(3'b001, {16'h0, 16'h0, 16'h00BB}, 1'b0, 1'b0);
        idle(22, 1'b1);
        step(3'b010, {16'h0, 16'h0077, 16'h0}, 1'b0, 1'b1);
        look("scroll_ev", 2'd1, 16'h0077, 3'b111);
        idle(12, 1'b1);
        step(3'b100, {16'h0099, 16'h0, 16'h0}, 1'b1, 1'b1);
        look("clr", 2'd0, 16'h0, 3'b000);
        step(3'b101, {16'h0011, 16'h0, 16'h0022}, 1'b0, 1'b1);
        idle(3, 1'b1);
        @(posedge clk);
        #2;
        armed = 0;
        rst = 1'b1;
        ch_valid = '0;
        clr = 1'b0;
        scroll_en = 1'b0;
        #1;
        chk("arst_sel", 32'(sel_o), 0);
        chk("arst_data", 32'(data_o), 0);
        chk("arst_held", 32'(held_o), 0);
        chk("arst_upd", 32'(upd_o), 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        idle(8, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            rv = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 7)) : '0;
            for (int i = 0; i < N; i++)
                rd[i*W +: W] = $urandom_range(0, 1) ? W'($urandom_range(0, 3)) : W'($urandom);
            rc = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 59) == 0) rs = ~rs;
            step(rv, rd, rc, rs);
        end
        @(posedge clk);
        #2;
        armed = 0;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
Parametrised N-channel source selector for the 7-segment display path. Each producer (keypad operand entries, multiplier result, future sources) presents a value with a one-cycle valid strobe. The block captures every value and selects which one drives the BCD converter, in either fixed-priority "last event" mode or timed auto-scroll mode. It emits an update strobe whenever the displayed value changes.

Parameters:
N_CH, 3, number of source channels (>=2); channel index = priority, higher index wins
DATA_W, 16, width of each channel value and of data_o
DWELL_CYC, 50_000_000, clock cycles each captured channel is shown in scroll mode (>=2)
SEL_W, $clog2(N_CH), width of sel_o (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
ch_valid  input  N_CH  per-channel one-cycle capture strobe
ch_data  input  N_CH*DATA_W  channel i value at bits [i*DATA_W +: DATA_W]; narrower producers zero-extend
clr  input  1  synchronous clear of all captured values
scroll_en  input  1  level; 1 = auto-scroll mode, 0 = manual priority mode
sel_o  output  SEL_W  index of channel currently displayed
data_o  output  DATA_W  value to BCD converter, = cap[sel_o]
held_o  output  N_CH  bit i set once channel i has captured since reset/clr
upd_o  output  1  one-cycle pulse in the first cycle a new data_o/sel_o is visible

Behaviour:
- Reset (async, rst=1): all cap[i]=0, held_o=0, sel_o=0, data_o=0, upd_o=0, dwell counter=0, FSM=S_MANUAL.
- Capture: at edge where ch_valid[i]=1, cap[i]<=channel i data, held_o[i]<=1. Multiple channels may capture in the same cycle.
- data_o is driven from registered cap/sel; latency from ch_valid to data_o = 1 cycle.
- upd_o registered: 1 in the cycle after an edge where sel_o or cap[sel_o] changed value; 0 otherwise. Recapturing an identical value on the selected channel gives no pulse.
- clr: at edge, cap=0, held_o=0, sel_o=0, counter=0; clr wins over ch_valid in the same cycle (data dropped). upd_o pulses if data_o or sel_o changed.
- FSM states: S_MANUAL, S_DWELL, S_ADVANCE.
- S_MANUAL (scroll_en=0): any ch_valid -> sel_o <= highest asserted index. No valid -> sel_o holds. scroll_en=1 -> S_DWELL, counter=0.
- S_DWELL: counter increments each cycle. At counter=DWELL_CYC-1 -> S_ADVANCE. Any ch_valid -> capture, sel_o <= highest asserted index, counter=0, stay in S_DWELL.
- S_ADVANCE (one cycle): sel_o <= next index above sel_o with held_o set, wrapping N_CH-1 -> 0. If no other channel is held, sel_o is unchanged. If none is held, sel_o=0. Counter=0, return to S_DWELL. A ch_valid in this cycle takes precedence over advance (same as S_DWELL rule).
- scroll_en=0 in S_DWELL/S_ADVANCE -> S_MANUAL next edge, sel_o kept, counter=0.
- Non-power-of-two N_CH: sel values >= N_CH are unreachable; if forced, data_o=0.
- No arithmetic beyond the counter; the counter width is $clog2(DWELL_CYC) and it never wraps past DWELL_CYC-1.

Test Plan:
1. Reset then idle, N_CH=3: sel_o=0, data_o=0, held_o=3'b000, upd_o=0 for 20 cycles.
2. Manual mode: ch_valid=001 with data 0x0012, later 010 with 0x0034 -> data_o=0x0012 then 0x0034 one cycle after each strobe. upd_o pulses once per change. held_o=011.
3. Simultaneous ch_valid=111 with data 0x0001/0x0002/0x00C8 -> sel_o=2, data_o=0x00C8. Then a ch_valid=001 strobe with 0x0005 -> sel_o=0, data_o=0x0005. Repeating 0x0005 -> no upd_o.
4. Scroll, DWELL_CYC=4, held=101, start sel=0 -> sel_o sequence 0,2,0,2 with a change every 5 cycles (4 dwell + 1 advance), skipping channel 1. upd_o is 1 at each change.
5. Scroll with valid mid-dwell: ch_valid=010 with 0x0077 at dwell count 2 -> sel_o=1, data_o=0x0077 next cycle, counter restarts, next advance 5 cycles later to index 2.
6. clr together with ch_valid=100 -> held_o=000, data_o=0, data dropped. Async rst asserted mid-dwell -> all outputs 0 immediately, FSM S_MANUAL.
